flash_reader: RTL and testbench

FLASH_READER -- requirements
Module: flash_reader

---
 rtl/flash_reader.sv | 185 ++++++++++++++++++
 tb/tb_flash_reader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_reader.sv
// Multi-channel burst reader for a parallel NOR flash with round-robin arbitration.
// Optional macro FLASH_READ_ARRAY_CMD_EN prefixes each burst with a Read-Array (0x00FF) command write.
module flash_reader #(
    parameter int ADDR_W   = 23,
    parameter int DATA_W   = 16,
    parameter int N_CH     = 2,
    parameter int LEN_W    = 4,
    parameter int WAIT_CYC = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH*ADDR_W-1:0]   addr,
    input  logic [N_CH*LEN_W-1:0]    len,
    output logic [N_CH-1:0]          gnt,
    output logic [DATA_W-1:0]        rdata,
    output logic [N_CH-1:0]          rvalid,
    output logic [N_CH-1:0]          done,
    output logic                     busy,
    output logic [ADDR_W-1:0]        flash_a,
    inout  wire  [DATA_W-1:0]        flash_d,
    output logic                     flash_rp_n,
    output logic                     flash_vpen,
    output logic                     flash_ce_n,
    output logic                     flash_oe_n,
    output logic                     flash_we_n,
    output logic                     flash_byte_n,
    output logic [2:0]               dbg_state_o
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CMD_SETUP = 3'd1;
    localparam logic [2:0] CMD_WE    = 3'd2;
    localparam logic [2:0] CMD_HOLD  = 3'd3;
    localparam logic [2:0] RD_ADDR   = 3'd4;
    localparam logic [2:0] RD_WAIT   = 3'd5;
    localparam logic [2:0] RD_SAMPLE = 3'd6;
    localparam logic [2:0] DONE      = 3'd7;

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [2:0]        state_q, state_d;
    logic [N_CH-1:0]   gnt_q, gnt_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [3:0]        wait_q, wait_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [N_CH-1:0]   rvalid_q, rvalid_d;

    logic              pick_found;
    logic [CH_W-1:0]   pick_idx;
    logic [CH_W-1:0]   ptr_nxt;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic              rd_phase;
    int                cand;

    // Search channels starting at ptr_q; ptr_q always holds the channel after the last grant.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 0; k < N_CH; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N_CH) cand = cand - N_CH;
            for (int j = 0; j < N_CH; j++) begin
                if (!pick_found && cand == j && req[j]) begin
                    pick_found = 1'b1;
                    pick_idx   = CH_W'(j);
                end
            end
        end
        sel_addr = '0;
        sel_len  = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (pick_idx == CH_W'(j)) begin
                sel_addr = addr[j*ADDR_W +: ADDR_W];
                sel_len  = len[j*LEN_W +: LEN_W];
            end
        end
        ptr_nxt = (pick_idx == CH_W'(N_CH-1)) ? '0 : pick_idx + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        len_d    = len_q;
        wait_d   = wait_q;
        rdata_d  = rdata_q;
        rvalid_d = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d  = N_CH'(1) << pick_idx;
                    ptr_d  = ptr_nxt;
                    addr_d = sel_addr;
                    len_d  = sel_len;
`ifdef FLASH_READ_ARRAY_CMD_EN
                    state_d = CMD_SETUP;
`else
                    state_d = RD_ADDR;
`endif
                end
            end
            CMD_SETUP: state_d = CMD_WE;
            CMD_WE:    state_d = CMD_HOLD;
            CMD_HOLD:  state_d = RD_ADDR;
            RD_ADDR: begin
                wait_d  = 4'(WAIT_CYC - 1);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (wait_q == 4'd0) state_d = RD_SAMPLE;
                else                wait_d  = wait_q - 1'b1;
            end
            RD_SAMPLE: begin
                rdata_d  = flash_d;
                rvalid_d = gnt_q;
                if (len_q == '0) begin
                    state_d = DONE;
                end else begin
                    len_d   = len_q - 1'b1;
                    addr_d  = addr_q + 1'b1;
                    state_d = RD_ADDR;
                end
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            ptr_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            wait_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            wait_q   <= wait_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rd_phase     = (state_q == RD_ADDR) || (state_q == RD_WAIT) || (state_q == RD_SAMPLE);
    assign gnt          = gnt_q;
    assign busy         = (state_q != IDLE);
    assign rdata        = rdata_q;
    assign rvalid       = rvalid_q;
    assign done         = (state_q == DONE) ? gnt_q : '0;
    assign flash_a      = rd_phase ? addr_q : '0;
    assign flash_ce_n   = (state_q == IDLE) || (state_q == DONE);
    assign flash_oe_n   = !rd_phase;
    assign flash_rp_n   = 1'b1;
    assign flash_vpen   = 1'b1;
    assign flash_byte_n = 1'b1;
    assign dbg_state_o  = state_q;

`ifdef FLASH_READ_ARRAY_CMD_EN
    localparam logic [DATA_W-1:0] CMD_WORD = DATA_W'(8'hFF);
    logic cmd_phase;
    assign cmd_phase  = (state_q == CMD_SETUP) || (state_q == CMD_WE) || (state_q == CMD_HOLD);
    assign flash_we_n = (state_q != CMD_WE);
    assign flash_d    = cmd_phase ? CMD_WORD : {DATA_W{1'bz}};
`else
    assign flash_we_n = 1'b1;
    assign flash_d    = {DATA_W{1'bz}};
`endif

endmodule

// File: tb/tb_flash_reader.sv
// Randomized self-checking bench for flash_reader: flash memory model, address/timing scoreboard, arbitration model.
module tb_flash_reader;
    localparam int AW = 23;
    localparam int DW = 16;
    localparam int NC = 2;
    localparam int LW = 4;
    localparam int WC = 3;
`ifdef FLASH_READ_ARRAY_CMD_EN
    localparam int CMD_N = 1;
`else
    localparam int CMD_N = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NC-1:0]    req;
    logic [NC*AW-1:0] addr;
    logic [NC*LW-1:0] len;
    logic [NC-1:0]    gnt, rvalid, done;
    logic [DW-1:0]    rdata;
    logic             busy;
    logic [AW-1:0]    flash_a;
    wire  [DW-1:0]    flash_d;
    logic             rp_n, vpen, ce_n, oe_n, we_n, byte_n;
    logic [2:0]       dbg;

    logic [NC-1:0]    req5;
    logic [NC*AW-1:0] addr5;
    logic [NC*LW-1:0] len5;
    logic [NC-1:0]    gnt5, rvalid5, done5;
    logic [DW-1:0]    rdata5;
    logic             busy5;
    logic [AW-1:0]    a5;
    wire  [DW-1:0]    flash_d5;
    logic             rp5_n, vpen5, ce5_n, oe5_n, we5_n, byte5_n;
    logic [2:0]       dbg5;

    function automatic logic [DW-1:0] flash_word(input logic [AW-1:0] a);
        if (a == 23'h000100) return 16'hBEEF;
        return a[15:0] ^ {a[22:16], 9'h0} ^ 16'h5A3C;
    endfunction

    assign flash_d  = (!oe_n && !ce_n) ? flash_word(flash_a) : 16'hzzzz;
    assign flash_d5 = (!oe5_n && !ce5_n) ? flash_word(a5) : 16'hzzzz;

    flash_reader u_dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .len(len),
        .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .done(done), .busy(busy),
        .flash_a(flash_a), .flash_d(flash_d), .flash_rp_n(rp_n), .flash_vpen(vpen),
        .flash_ce_n(ce_n), .flash_oe_n(oe_n), .flash_we_n(we_n), .flash_byte_n(byte_n),
        .dbg_state_o(dbg)
    );

    flash_reader #(.WAIT_CYC(5)) u_dut5 (
        .clk(clk), .rst(rst), .req(req5), .addr(addr5), .len(len5),
        .gnt(gnt5), .rdata(rdata5), .rvalid(rvalid5), .done(done5), .busy(busy5),
        .flash_a(a5), .flash_d(flash_d5), .flash_rp_n(rp5_n), .flash_vpen(vpen5),
        .flash_ce_n(ce5_n), .flash_oe_n(oe5_n), .flash_we_n(we5_n), .flash_byte_n(byte5_n),
        .dbg_state_o(dbg5)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard: expected word addresses of the current burst, and observed word starts.
    logic [AW-1:0] exp_addr_q[$];
    int            start_cyc_q[$];
    logic [AW-1:0] start_addr_q[$];
    int            cur_ch = 0;
    int            rr_model = 0;
    int            we_low_cnt = 0, we_ok_cnt = 0, rv_cnt = 0, done_cnt = 0, multi_gnt_cnt = 0;
    logic          prev_oe_n = 1'b1;
    logic [AW-1:0] prev_a = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_oe_n = 1'b1;
        end else begin
            if ($countones(gnt) > 1) multi_gnt_cnt++;
            if (!we_n) begin
                we_low_cnt++;
                if (flash_d == 16'h00FF) we_ok_cnt++;
            end
            if (!oe_n && (prev_oe_n || flash_a != prev_a)) begin
                start_cyc_q.push_back(cyc);
                start_addr_q.push_back(flash_a);
            end
            prev_oe_n = oe_n;
            prev_a    = flash_a;
            if (rvalid != 0) begin
                rv_cnt++;
                if (exp_addr_q.size() == 0 || start_cyc_q.size() == 0) begin
                    chk("rvalid_unexpected", 64'(rvalid), 0);
                end else begin
                    logic [AW-1:0] ea, sa;
                    int sc;
                    ea = exp_addr_q.pop_front();
                    sc = start_cyc_q.pop_front();
                    sa = start_addr_q.pop_front();
                    chk("rvalid_ch", 64'(rvalid), 64'd1 << cur_ch);
                    chk("word_addr", 64'(sa), 64'(ea));
                    chk("rdata", 64'(rdata), 64'(flash_word(ea)));
                    chk("word_latency", 64'(cyc - sc), 64'(WC + 2));
                end
            end
            if (done != 0) begin
                done_cnt++;
                chk("done_ch", 64'(done), 64'd1 << cur_ch);
                chk("words_left", 64'(exp_addr_q.size()), 0);
            end
        end
    end

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (gnt != 0) ok = 1'b1;
        end
        chk("gnt_wait", 64'(ok), 1);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            if (done != 0) ok = 1'b1;
        end
        chk("done_wait", 64'(ok), 1);
    endtask

    task automatic check_reset_outputs(input string p);
        chk({p, "_gnt"}, 64'(gnt), 0);
        chk({p, "_busy"}, 64'(busy), 0);
        chk({p, "_rvalid"}, 64'(rvalid), 0);
        chk({p, "_done"}, 64'(done), 0);
        chk({p, "_rdata"}, 64'(rdata), 0);
        chk({p, "_flash_a"}, 64'(flash_a), 0);
        chk({p, "_ctrl_n"}, 64'({ce_n, oe_n, we_n}), 64'h7);
        chk({p, "_static"}, 64'({rp_n, vpen, byte_n}), 64'h7);
    endtask

    task automatic do_burst(input int ch, input logic [AW-1:0] a, input int l);
        int w0, o0, r0, d0;
        bit ok;
        w0 = we_low_cnt; o0 = we_ok_cnt; r0 = rv_cnt; d0 = done_cnt;
        cur_ch = ch;
        for (int i = 0; i <= l; i++) exp_addr_q.push_back(a + 23'(i));
        addr[ch*AW +: AW] = a;
        len[ch*LW +: LW]  = 4'(l);
        req[ch] = 1'b1;
        wait_gnt(ok);
        chk("gnt", 64'(gnt), 64'd1 << ch);
        chk("busy", 64'(busy), 1);
        req[ch] = 1'b0;
        addr = 46'({$urandom, $urandom});
        len  = 8'($urandom);
        wait_done((l + 1) * (WC + 3) + 20, ok);
        @(posedge clk); #1;
        chk("gnt_end", 64'(gnt), 0);
        chk("busy_end", 64'(busy), 0);
        @(negedge clk);
        chk("we_pulses", 64'(we_low_cnt - w0), 64'(CMD_N));
        chk("we_cmd_data", 64'(we_ok_cnt - o0), 64'(CMD_N));
        chk("rv_count", 64'(rv_cnt - r0), 64'(l + 1));
        chk("done_count", 64'(done_cnt - d0), 1);
        rr_model = (ch + 1) % NC;
    endtask

    task automatic arb_test(input int n);
        logic [AW-1:0] a [NC];
        int l [NC];
        int exp_ch, r0;
        bit ok;
        for (int c = 0; c < NC; c++) begin
            a[c] = 23'($urandom);
            l[c] = $urandom_range(0, 2);
            addr[c*AW +: AW] = a[c];
            len[c*LW +: LW]  = 4'(l[c]);
        end
        req = '1;
        for (int t = 0; t < n; t++) begin
            exp_ch = rr_model;
            r0 = rv_cnt;
            wait_gnt(ok);
            chk("arb_gnt", 64'(gnt), 64'd1 << exp_ch);
            cur_ch = exp_ch;
            for (int i = 0; i <= l[exp_ch]; i++) exp_addr_q.push_back(a[exp_ch] + 23'(i));
            if (t == n - 1) req = '0;
            wait_done((l[exp_ch] + 1) * (WC + 3) + 20, ok);
            @(posedge clk); #1;
            chk("arb_rv_count", 64'(rv_cnt - r0), 64'(l[exp_ch] + 1));
            rr_model = (exp_ch + 1) % NC;
        end
        chk("arb_idle", 64'(busy), 0);
    endtask

    task automatic reset_test();
        bit ok;
        int d0;
        logic [AW-1:0] a;
        a = 23'($urandom);
        cur_ch = 0;
        for (int i = 0; i <= 7; i++) exp_addr_q.push_back(a + 23'(i));
        addr[0 +: AW] = a;
        len[0 +: LW]  = 4'd7;
        req[0] = 1'b1;
        wait_gnt(ok);
        req[0] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (!oe_n) ok = 1'b1;
        end
        chk("rd_start_wait", 64'(ok), 1);
        @(posedge clk); #1;
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        exp_addr_q.delete();
        start_cyc_q.delete();
        start_addr_q.delete();
        rr_model = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 0);
        chk("abort_idle", 64'(busy), 0);
    endtask

    task automatic wait5_test();
        int t0, t1;
        bit ok;
        logic [AW-1:0] a;
        t0 = 0; t1 = 0;
        a = 23'($urandom);
        addr5 = {23'd0, a};
        len5  = '0;
        req5  = 2'b01;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (!oe5_n) begin ok = 1'b1; t0 = cyc; end
        end
        chk("w5_addr_wait", 64'(ok), 1);
        chk("w5_flash_a", 64'(a5), 64'(a));
        req5 = '0;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(posedge clk); #1;
            if (rvalid5 != 0) begin ok = 1'b1; t1 = cyc; end
        end
        chk("w5_rv_wait", 64'(ok), 1);
        chk("w5_latency", 64'(t1 - t0), 7);
        chk("w5_rvalid", 64'(rvalid5), 1);
        chk("w5_rdata", 64'(rdata5), 64'(flash_word(a)));
        chk("w5_done", 64'(done5), 1);
    endtask

    initial begin
        req = '0; addr = '0; len = '0;
        req5 = '0; addr5 = '0; len5 = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        chk("rst_w5_busy", 64'(busy5), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_burst(0, 23'h000100, 0);
        do_burst(1, 23'h7FFFFE, 3);
        do_burst(0, 23'h000200, 1);
        arb_test(4);
        for (int i = 0; i < 6; i++) begin
            int ch, l;
            logic [AW-1:0] a;
            ch = $urandom_range(0, 1);
            l  = $urandom_range(0, 3);
            a  = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF - 23'($urandom_range(0, 2)) : 23'($urandom);
            do_burst(ch, a, l);
        end
        reset_test();
        arb_test(2);
        do_burst(1, 23'($urandom), 2);
        chk("one_hot_gnt", 64'(multi_gnt_cnt), 0);
        wait5_test();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
